// File: rtl/modport_mac_pkg.sv
// Shared types and defaults for the modport_mac loopback MAC.
package modport_mac_pkg;

  localparam int unsigned DataW         = 64;
  localparam int unsigned ModW          = 3;
  localparam int unsigned DefDepth      = 256;
  localparam int unsigned DefFullMargin = 8;

  // One FIFO word: 70 bits, data in the top bits.
  typedef struct packed {
    logic [DataW-1:0] data;
    logic             sop;
    logic             eop;
    logic [ModW-1:0]  mod;
    logic             err;
  } mac_entry_t;

  typedef enum logic {
    StIdle,
    StInPkt
  } framer_state_e;

endpackage

// File: rtl/modport_mac_fifo.sv
// Synchronous FIFO of mac_entry_t. Callers gate wr_en_i/rd_en_i with full_o/empty_o.
// free_o is the free-entry count after the current edge's write/read.
module modport_mac_fifo
  import modport_mac_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset_156m25,
  input  logic       wr_en_i,
  input  mac_entry_t wr_entry_i,
  input  logic       rd_en_i,
  output mac_entry_t rd_entry_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [AW:0] free_o
);

  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

  mac_entry_t  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count, count_d;

  // Pointer advance; the extra MSB separates full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en_i);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en_i);
    count    = wr_ptr_q - rd_ptr_q;
    count_d  = wr_ptr_d - rd_ptr_d;
    full_o   = (count == DepthW);
    empty_o  = (count == '0);
    free_o   = DepthW - count_d;
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset_156m25) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry_i;
  end

  assign rd_entry_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/modport_mac.sv
// Packet loopback MAC: TX framer -> packet FIFO -> registered RX port.
// Define MODPORT_MAC_ERR_CHECK_EN to enable orphan-drop and mid-packet abort handling;
// otherwise every valid TX word is stored verbatim with err=0.
module modport_mac
  import modport_mac_pkg::*;
#(
  parameter int unsigned DEPTH       = DefDepth,
  parameter int unsigned FULL_MARGIN = DefFullMargin
) (
  input  logic             clk,
  input  logic             reset_156m25,
  input  logic             pkt_tx_val,
  input  logic             pkt_tx_sop,
  input  logic             pkt_tx_eop,
  input  logic [ModW-1:0]  pkt_tx_mod,
  input  logic [DataW-1:0] pkt_tx_data,
  output logic             pkt_tx_full,
  input  logic             pkt_rx_ren,
  output logic             pkt_rx_avail,
  output logic             pkt_rx_val,
  output logic             pkt_rx_sop,
  output logic             pkt_rx_eop,
  output logic [ModW-1:0]  pkt_rx_mod,
  output logic [DataW-1:0] pkt_rx_data,
  output logic             pkt_rx_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  mac_entry_t  wr_entry, head;
  logic        wr_req, wr_fire, rd_fire;
  logic        fifo_full, fifo_empty;
  logic [AW:0] free;
  logic [AW:0] pkt_cnt_q, pkt_cnt_d;

  logic             tx_full_d, avail_d;
  logic             rx_val_d, rx_sop_d, rx_eop_d, rx_err_d;
  logic [ModW-1:0]  rx_mod_d;
  logic [DataW-1:0] rx_data_d;

`ifdef MODPORT_MAC_ERR_CHECK_EN
  framer_state_e state_q, state_d;

  // Framer: drop orphans in idle, close a packet interrupted by a new sop with an err word.
  always_comb begin
    wr_req   = 1'b0;
    wr_entry = '{data: pkt_tx_data, sop: pkt_tx_sop, eop: pkt_tx_eop, mod: pkt_tx_mod,
                 err: 1'b0};
    state_d  = state_q;
    case (state_q)
      StIdle: begin
        if (pkt_tx_val && pkt_tx_sop) begin
          wr_req = 1'b1;
          if (!fifo_full && !pkt_tx_eop) state_d = StInPkt;
        end
      end
      StInPkt: begin
        if (pkt_tx_val) begin
          wr_req = 1'b1;
          if (pkt_tx_sop) begin
            wr_entry.sop = 1'b0;
            wr_entry.eop = 1'b1;
            wr_entry.mod = '0;
            wr_entry.err = 1'b1;
          end
          // A dropped write (FIFO full) leaves the framer where it was.
          if (!fifo_full && (pkt_tx_sop || pkt_tx_eop)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Framer state register.
  always_ff @(posedge clk) begin
    if (reset_156m25) state_q <= StIdle;
    else              state_q <= state_d;
  end
`else
  // Pass-through: every valid word is stored as presented.
  always_comb begin
    wr_req   = pkt_tx_val;
    wr_entry = '{data: pkt_tx_data, sop: pkt_tx_sop, eop: pkt_tx_eop, mod: pkt_tx_mod,
                 err: 1'b0};
  end
`endif

  assign wr_fire = wr_req & ~fifo_full;
  assign rd_fire = pkt_rx_ren & ~fifo_empty;

  modport_mac_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset_156m25 (reset_156m25),
    .wr_en_i      (wr_fire),
    .wr_entry_i   (wr_entry),
    .rd_en_i      (rd_fire),
    .rd_entry_o   (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .free_o       (free)
  );

  // Packet count, status flags and the next RX word (all zero when nothing is popped).
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (wr_fire && wr_entry.eop) pkt_cnt_d = pkt_cnt_d + 1'b1;
    if (rd_fire && head.eop)     pkt_cnt_d = pkt_cnt_d - 1'b1;
    avail_d   = (pkt_cnt_d != '0);
    tx_full_d = (free <= (AW+1)'(FULL_MARGIN));
    rx_val_d  = rd_fire;
    rx_sop_d  = rd_fire & head.sop;
    rx_eop_d  = rd_fire & head.eop;
    rx_err_d  = rd_fire & head.err;
    rx_mod_d  = (rd_fire && head.eop) ? head.mod : '0;
    rx_data_d = rd_fire ? head.data : '0;
  end

  // Output and counter registers.
  always_ff @(posedge clk) begin
    if (reset_156m25) begin
      pkt_cnt_q    <= '0;
      pkt_rx_avail <= 1'b0;
      pkt_tx_full  <= 1'b0;
      pkt_rx_val   <= 1'b0;
      pkt_rx_sop   <= 1'b0;
      pkt_rx_eop   <= 1'b0;
      pkt_rx_err   <= 1'b0;
      pkt_rx_mod   <= '0;
      pkt_rx_data  <= '0;
    end else begin
      pkt_cnt_q    <= pkt_cnt_d;
      pkt_rx_avail <= avail_d;
      pkt_tx_full  <= tx_full_d;
      pkt_rx_val   <= rx_val_d;
      pkt_rx_sop   <= rx_sop_d;
      pkt_rx_eop   <= rx_eop_d;
      pkt_rx_err   <= rx_err_d;
      pkt_rx_mod   <= rx_mod_d;
      pkt_rx_data  <= rx_data_d;
    end
  end

endmodule

// File: tb/tb_modport_mac.sv
// Scoreboard bench for modport_mac: expected RX words are queued as TX words are driven
// and compared as the DUT presents them.
module tb_modport_mac;

  logic        clk = 1'b0;
  logic        reset_156m25;
  logic        pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
  logic [2:0]  pkt_tx_mod;
  logic [63:0] pkt_tx_data;
  logic        pkt_tx_full;
  logic        pkt_rx_ren;
  logic        pkt_rx_avail, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err;
  logic [2:0]  pkt_rx_mod;
  logic [63:0] pkt_rx_data;

  int n_total = 0;
  int n_bad   = 0;
  logic [69:0] exp_q [$];

  modport_mac dut (
    .clk          (clk),
    .reset_156m25 (reset_156m25),
    .pkt_tx_val   (pkt_tx_val),
    .pkt_tx_sop   (pkt_tx_sop),
    .pkt_tx_eop   (pkt_tx_eop),
    .pkt_tx_mod   (pkt_tx_mod),
    .pkt_tx_data  (pkt_tx_data),
    .pkt_tx_full  (pkt_tx_full),
    .pkt_rx_ren   (pkt_rx_ren),
    .pkt_rx_avail (pkt_rx_avail),
    .pkt_rx_val   (pkt_rx_val),
    .pkt_rx_sop   (pkt_rx_sop),
    .pkt_rx_eop   (pkt_rx_eop),
    .pkt_rx_mod   (pkt_rx_mod),
    .pkt_rx_data  (pkt_rx_data),
    .pkt_rx_err   (pkt_rx_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [69:0] obs, input logic [69:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [69:0] ent(input logic [63:0] d, input logic s, input logic e,
                                      input logic [2:0] m, input logic er);
    return {d, s, e, m, er};
  endfunction

  // RX monitor: every valid word must match the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    if (pkt_rx_val) begin
      if (exp_q.size() == 0) check_eq("rx_unexpected", 70'(1), 70'(0));
      else check_eq("rx_word", {pkt_rx_data, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_err},
                    exp_q.pop_front());
    end
  end

  task automatic send_word(input logic s, input logic e, input logic [2:0] m,
                           input logic [63:0] d);
    @(negedge clk);
    pkt_tx_val  = 1'b1;
    pkt_tx_sop  = s;
    pkt_tx_eop  = e;
    pkt_tx_mod  = m;
    pkt_tx_data = d;
  endtask

  task automatic idle_tx();
    @(negedge clk);
    pkt_tx_val = 1'b0;
    pkt_tx_sop = 1'b0;
    pkt_tx_eop = 1'b0;
    pkt_tx_mod = '0;
    pkt_tx_data = '0;
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pkt_rx_ren = 1'b1;
    end
    @(negedge clk);
    pkt_rx_ren = 1'b0;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_eq({pfx, "_val"},   70'(pkt_rx_val),   70'(0));
    check_eq({pfx, "_avail"}, 70'(pkt_rx_avail), 70'(0));
    check_eq({pfx, "_full"},  70'(pkt_tx_full),  70'(0));
    check_eq({pfx, "_word"},
             {pkt_rx_data, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_err}, 70'(0));
  endtask

  initial begin
    reset_156m25 = 1'b1;
    pkt_tx_val = 1'b0; pkt_tx_sop = 1'b0; pkt_tx_eop = 1'b0;
    pkt_tx_mod = '0;   pkt_tx_data = '0;  pkt_rx_ren = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_156m25 = 1'b0;

    // Single-word packet.
    send_word(1'b1, 1'b1, 3'd4, 64'h0011223344556677);
    exp_q.push_back(ent(64'h0011223344556677, 1'b1, 1'b1, 3'd4, 1'b0));
    idle_tx();
    check_eq("single_avail", 70'(pkt_rx_avail), 70'(1));
    read_n(1);
    check_eq("single_avail_low", 70'(pkt_rx_avail), 70'(0));

    // Three-word packet; mod on a middle word must read back as 0.
    send_word(1'b1, 1'b0, 3'd0, 64'd1);
    send_word(1'b0, 1'b0, 3'd5, 64'd2);
    send_word(1'b0, 1'b1, 3'd0, 64'd3);
    idle_tx();
    exp_q.push_back(ent(64'd1, 1'b1, 1'b0, 3'd0, 1'b0));
    exp_q.push_back(ent(64'd2, 1'b0, 1'b0, 3'd0, 1'b0));
    exp_q.push_back(ent(64'd3, 1'b0, 1'b1, 3'd0, 1'b0));
    check_eq("three_avail", 70'(pkt_rx_avail), 70'(1));
    read_n(3);
    check_eq("three_avail_low", 70'(pkt_rx_avail), 70'(0));

    // Abort: sop A, B, sop C, then trailing non-sop words D, E.
    send_word(1'b1, 1'b0, 3'd0, 64'hA);
    send_word(1'b0, 1'b0, 3'd0, 64'hB);
    send_word(1'b1, 1'b0, 3'd0, 64'hC);
    send_word(1'b0, 1'b0, 3'd0, 64'hD);
    send_word(1'b0, 1'b1, 3'd0, 64'hE);
    idle_tx();
    exp_q.push_back(ent(64'hA, 1'b1, 1'b0, 3'd0, 1'b0));
    exp_q.push_back(ent(64'hB, 1'b0, 1'b0, 3'd0, 1'b0));
`ifdef MODPORT_MAC_ERR_CHECK_EN
    exp_q.push_back(ent(64'hC, 1'b0, 1'b1, 3'd0, 1'b1));
    check_eq("abort_avail", 70'(pkt_rx_avail), 70'(1));
    read_n(3);
`else
    exp_q.push_back(ent(64'hC, 1'b1, 1'b0, 3'd0, 1'b0));
    exp_q.push_back(ent(64'hD, 1'b0, 1'b0, 3'd0, 1'b0));
    exp_q.push_back(ent(64'hE, 1'b0, 1'b1, 3'd0, 1'b0));
    check_eq("abort_avail", 70'(pkt_rx_avail), 70'(1));
    read_n(5);
`endif
    check_eq("abort_avail_low", 70'(pkt_rx_avail), 70'(0));
    read_n(2); // any leftover word shows up as rx_unexpected

    // Orphan word in idle.
    send_word(1'b0, 1'b1, 3'd3, 64'h0BAD);
    idle_tx();
`ifdef MODPORT_MAC_ERR_CHECK_EN
    check_eq("orphan_avail", 70'(pkt_rx_avail), 70'(0));
`else
    exp_q.push_back(ent(64'h0BAD, 1'b0, 1'b1, 3'd3, 1'b0));
    check_eq("orphan_avail", 70'(pkt_rx_avail), 70'(1));
`endif
    read_n(1);
    check_eq("orphan_drained", 70'(exp_q.size()), 70'(0));

    // Fill to 248 entries; full must assert exactly when free drops to 8.
    for (int i = 1; i <= 248; i++) begin
      send_word(1'b1, 1'b1, 3'd0, 64'h1000 + 64'(i));
      exp_q.push_back(ent(64'h1000 + 64'(i), 1'b1, 1'b1, 3'd0, 1'b0));
      idle_tx();
      if (i >= 244) check_eq($sformatf("fill_full_%0d", i), 70'(pkt_tx_full),
                             70'(i >= 248));
    end
    // Same-edge write and read at the boundary keeps the count at 248.
    @(negedge clk);
    pkt_tx_val = 1'b1; pkt_tx_sop = 1'b1; pkt_tx_eop = 1'b1;
    pkt_tx_mod = 3'd7; pkt_tx_data = 64'h5A5A;
    pkt_rx_ren = 1'b1;
    exp_q.push_back(ent(64'h5A5A, 1'b1, 1'b1, 3'd7, 1'b0));
    @(negedge clk);
    pkt_tx_val = 1'b0; pkt_tx_sop = 1'b0; pkt_tx_eop = 1'b0; pkt_rx_ren = 1'b0;
    check_eq("same_edge_full", 70'(pkt_tx_full), 70'(1));
    read_n(1);
    check_eq("free9_full", 70'(pkt_tx_full), 70'(0));
    read_n(247);
    check_eq("fill_drained", 70'(exp_q.size()), 70'(0));
    check_eq("fill_avail_low", 70'(pkt_rx_avail), 70'(0));

    // Reset while reading a 3-word packet.
    send_word(1'b1, 1'b0, 3'd0, 64'h21);
    send_word(1'b0, 1'b0, 3'd0, 64'h22);
    send_word(1'b0, 1'b1, 3'd2, 64'h23);
    idle_tx();
    exp_q.push_back(ent(64'h21, 1'b1, 1'b0, 3'd0, 1'b0));
    exp_q.push_back(ent(64'h22, 1'b0, 1'b0, 3'd0, 1'b0));
    exp_q.push_back(ent(64'h23, 1'b0, 1'b1, 3'd2, 1'b0));
    @(negedge clk);
    pkt_rx_ren = 1'b1;
    @(negedge clk);
    reset_156m25 = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    exp_q.delete();
    reset_156m25 = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_reset_val", 70'(pkt_rx_val), 70'(0));
    check_eq("post_reset_avail", 70'(pkt_rx_avail), 70'(0));
    pkt_rx_ren = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("final_empty", 70'(exp_q.size()), 70'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/modport_mac.md
# modport_mac

Single-clock 64-bit packet loopback MAC core. It accepts framed packets on a TX packet interface (valid/sop/eop/mod/data with a full back-pressure flag) and buffers them in an internal packet FIFO. It presents complete packets on an RX packet interface with an availability flag and a read-enable/valid handshake. It sits between the testbench packet driver/monitor and the switch fabric.

## Interface
- `DEPTH`, 256: FIFO entries (64-bit words); power of two.
- `FULL_MARGIN`, 8: `pkt_tx_full` asserts when free entries ≤ this value.
- `clk` in 1: single clock (156.25 MHz domain).
- `reset_156m25` in 1: reset. **One clock; reset is synchronous and active-high.**
- `pkt_tx_val` in 1: TX word valid.
- `pkt_tx_sop` in 1: first word of packet.
- `pkt_tx_eop` in 1: last word of packet.
- `pkt_tx_mod` in 3: valid bytes on the eop word; 0 means 8.
- `pkt_tx_data` in 64: TX word.
- `pkt_tx_full` out 1: FIFO near full; the sender must stop after the current packet.
- `pkt_rx_ren` in 1: RX read enable.
- `pkt_rx_avail` out 1: at least one complete packet is stored.
- `pkt_rx_val` out 1: RX word valid.
- `pkt_rx_sop`, `pkt_rx_eop` out 1: framing of the RX word.
- `pkt_rx_mod` out 3: eop byte count; 0 on non-eop words.
- `pkt_rx_data` out 64: RX word.
- `pkt_rx_err` out 1: word closes an aborted packet.

## Operation
- **FIFO entry format:** {data[63:0], sop, eop, mod[2:0], err}, 70 bits.
- **TX framer states:** IDLE and IN_PKT.
  - IDLE + val + sop: write the word. If eop, stay IDLE; otherwise go to IN_PKT.
  - IDLE + val without sop: orphan word, dropped.
  - IN_PKT + val without sop: write the word. If eop, return to IDLE.
  - IN_PKT + val + sop: abort. Store the word with eop=1, err=1, sop=0, mod=0, which closes the broken packet. Go to IDLE.
- **Packet counter** `pkt_cnt`:
  - Increments when an eop-flagged entry is written.
  - Decrements when an eop entry is read.
  - A simultaneous increment and decrement leaves it unchanged.
- **RX read:** `pkt_rx_ren` while the FIFO is non-empty pops one entry. Ren while the FIFO is empty is ignored.
- **Write to a completely full FIFO:** the word is dropped and the framer state is unchanged. Honouring `pkt_tx_full` makes this unreachable.
- **Pointers:** wrap modulo `DEPTH`. An extra pointer bit distinguishes full from empty.

## Timing
- **Reset values:** all outputs 0, FIFO empty, `pkt_cnt`=0, framer IDLE. Reset mid-packet discards all stored data.
- **TX sampling:** TX inputs are sampled at the posedge. A word accepted at edge k is readable from edge k+1.
- **`pkt_rx_avail`:** registered as `pkt_cnt`≠0. It rises in the cycle after the eop write edge and falls in the cycle after the eop read edge.
- **RX read latency:** ren high at edge k gives `pkt_rx_val` plus word fields registered at edge k, i.e. one-cycle latency. `pkt_rx_val`=0 in cycles with no pop.
- **`pkt_tx_full`:** registered from the free count after the current edge's write/read.
- **Same-edge read and write:** both are legal, including on the same entry count boundary.

## Configuration
- `MODPORT_MAC_ERR_CHECK_EN` defined: framer and abort behaviour as above.
- Macro undefined:
  - Every `pkt_tx_val` word is written verbatim (no orphan drop, no abort).
  - err is stored as 0, so `pkt_rx_err` is constant 0.
  - `pkt_cnt` increments on every written eop.

## Structure
- **Package `modport_mac_pkg`:**
  - Data/mod widths.
  - Entry struct `mac_entry_t`.
  - Framer state enum.
  - Default `DEPTH`/`FULL_MARGIN`.
- **Sub-module `modport_mac_fifo`:** synchronous FIFO of `mac_entry_t` with a free-count output.
- **Top:** framer, packet counter and RX output registers.

## Test plan
- **Single-word packet:** sop=eop=1, mod=4, data 0x0011223344556677 → avail high the next cycle. Ren gives val, sop, eop, mod=4, same data, err=0; avail low afterwards.
- **3-word packet then read:** data 1, 2, 3 with mod=0 → three consecutive ren cycles return 1/2/3, sop on word 1, eop on word 3.
- **Abort (macro on):** sop word A, word B, then sop word C → read A, B, then a word with eop=1, err=1. `pkt_cnt` is 1 and the following non-sop words are dropped.
- **Orphan word in IDLE:** val without sop → FIFO stays empty, avail stays 0.
- **Fill to `DEPTH`−`FULL_MARGIN` entries:**
  - `pkt_tx_full` asserts exactly when free ≤ 8.
  - Reading one word deasserts it when free becomes 9.
- **Reset asserted mid-read:** all outputs go to 0, avail=0, and a subsequent ren yields no val.
